// File: rtl/osc_pkg.sv
// Shared definitions for the ADC capture path: sample width, sync byte and capture states.
// The HDR state exists only when CAPTURE_HEADER_EN is defined.
package osc_pkg;

  localparam int ADC_W = 8;
  localparam logic [ADC_W-1:0] SYNC_BYTE = 8'hA5;

`ifdef CAPTURE_HEADER_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT_TRIG,
    ST_POST,
    ST_HDR,
    ST_DUMP
  } cap_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DUMP
  } cap_state_t;
`endif

  // Rising-level crossing; a sample equal to the level counts as reached.
  function automatic logic crossed(input logic [ADC_W-1:0] prev,
                                   input logic [ADC_W-1:0] cur,
                                   input logic [ADC_W-1:0] level);
    return (prev < level) && (cur >= level);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, single clock.
// No reset on the array so it maps onto block RAM.
module capture_ram
  import osc_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADC_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADC_W-1:0]  rd_data
);

  logic [ADC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Decimating ADC trigger/capture buffer that streams the frozen window oldest-first over valid/ready.
// Optional CAPTURE_HEADER_EN prefixes the dump with SYNC_BYTE and PRE_TRIG[7:0].
module adc_capture_buffer
  import osc_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int PRE_TRIG   = 64,
  parameter int SAMPLE_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adcIn,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             arm,
  output logic [ADC_W-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             triggered
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int POST_N = DEPTH - PRE_TRIG;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]  PRE_CNT    = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]  POST_CNT   = CNT_W'(POST_N);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_ADDR   = ADDR_W'(PRE_TRIG);

`ifdef CAPTURE_HEADER_EN
  localparam cap_state_t        ST_OUT   = ST_HDR;
  localparam logic [ADC_W-1:0]  PRE_BYTE = ADC_W'(PRE_TRIG);
`else
  localparam cap_state_t        ST_OUT   = ST_DUMP;
`endif

  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;

  logic [ADC_W-1:0]  sample_p0;
  logic              vld_p0;
  logic [ADC_W-1:0]  prev_p1;
  logic              prev_vld;

  cap_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] win_start;
  logic [CNT_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  post_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic              rd_pend;
`ifdef CAPTURE_HEADER_EN
  logic              hdr_cnt;
`endif

  logic              ram_we;
  logic              rd_en;
  logic [ADC_W-1:0]  rd_data;
  logic              hs;
  logic              trig_hit;
  logic              dump_go;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) div_cnt <= '0;
    else            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
  end

  // ---- stage p0: sample register, loaded once per tick ----
  always_ff @(posedge clk) begin
    if (tick) sample_p0 <= adcIn;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) vld_p0 <= 1'b0;
    else            vld_p0 <= tick;
  end

  // ---- stage p1: previous sample for edge detection ----
  always_ff @(posedge clk) begin
    if (vld_p0) prev_p1 <= sample_p0;
  end

  assign ram_we   = vld_p0 && (state inside {ST_FILL, ST_WAIT_TRIG, ST_POST});
  assign hs       = tx_valid && tx_ready;
  assign rd_en    = (state == ST_DUMP) && (rd_cnt != DEPTH_CNT) &&
                    ((!tx_valid && !rd_pend) || hs);
  assign trig_hit = vld_p0 && (state == ST_WAIT_TRIG) && prev_vld &&
                    crossed(prev_p1, sample_p0, trig_level);
  assign dump_go  = ((state == ST_WAIT_TRIG) && trig_hit && (POST_N == 1)) ||
                    ((state == ST_POST) && vld_p0 && (post_cnt + CNT_W'(1) == POST_CNT));
  // The window begins PRE_TRIG slots before the trigger sample, wrapping in the ring.
  assign win_start = ((state == ST_POST) ? trig_addr : wr_ptr) - PRE_ADDR;
  assign busy      = (state != ST_IDLE);

  capture_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (sample_p0),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trig_addr <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
      tx_cnt    <= '0;
      rd_pend   <= 1'b0;
      prev_vld  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      triggered <= 1'b0;
`ifdef CAPTURE_HEADER_EN
      hdr_cnt   <= 1'b0;
`endif
    end else begin
      rd_pend <= rd_en;
      if (rd_en) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        rd_cnt <= rd_cnt + CNT_W'(1);
      end

      // RAM data lands one cycle after the read; hold it until accepted.
      if (rd_pend) begin
        tx_data  <= rd_data;
        tx_valid <= 1'b1;
      end else if (hs) begin
        tx_valid <= 1'b0;
      end

      if (state == ST_IDLE) prev_vld <= 1'b0;
      else if (vld_p0)      prev_vld <= 1'b1;

      if (ram_we) wr_ptr <= wr_ptr + ADDR_W'(1);

      case (state)
        ST_IDLE: begin
          if (arm) begin
            state    <= (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_FILL;
            wr_ptr   <= '0;
            fill_cnt <= '0;
          end
        end
        ST_FILL: begin
          if (vld_p0) begin
            fill_cnt <= fill_cnt + CNT_W'(1);
            if (fill_cnt + CNT_W'(1) == PRE_CNT) state <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_hit) begin
            trig_addr <= wr_ptr;
            triggered <= 1'b1;
            post_cnt  <= CNT_W'(1);
            state     <= ST_POST;
          end
        end
        ST_POST: begin
          if (vld_p0) post_cnt <= post_cnt + CNT_W'(1);
        end
`ifdef CAPTURE_HEADER_EN
        ST_HDR: begin
          if (hs) begin
            hdr_cnt <= 1'b1;
            if (hdr_cnt) state <= ST_DUMP;
          end else if (!tx_valid) begin
            tx_data  <= hdr_cnt ? PRE_BYTE : SYNC_BYTE;
            tx_valid <= 1'b1;
          end
        end
`endif
        ST_DUMP: begin
          if (hs) begin
            tx_cnt <= tx_cnt + CNT_W'(1);
            if (tx_cnt == LAST_CNT) begin
              state     <= ST_IDLE;
              triggered <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (dump_go) begin
        state  <= ST_OUT;
        rd_ptr <= win_start;
        rd_cnt <= '0;
        tx_cnt <= '0;
`ifdef CAPTURE_HEADER_EN
        hdr_cnt <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer: scenario table plus reset-mid-dump sequence, checked
// against a sample-history reference model (define CAPTURE_HEADER_EN to expect the header).
`timescale 1ns/1ps
module tb_adc_capture_buffer;

  localparam int DEPTH      = 256;
  localparam int PRE_TRIG   = 64;
  localparam int SAMPLE_DIV = 16;
`ifdef CAPTURE_HEADER_EN
  localparam int HO = 2;
`else
  localparam int HO = 0;
`endif
  localparam int EXP_N = DEPTH + HO;

  logic       clk;
  logic       rst_n;
  logic [7:0] adcIn;
  logic [7:0] trig_level;
  logic       arm;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       triggered;

  adc_capture_buffer #(
    .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adcIn      (adcIn),
    .trig_level (trig_level),
    .arm        (arm),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .triggered  (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pat: 0 ramp from 30, 1 step 50->150 at sample 80, 2 random, 3 hold 200 then 50
  // rdy: 0 always ready, 1 random, 2 never ready
  typedef struct {
    int         pat;
    logic [7:0] level;
    int         rdy;
    bit         rearm;
    bit         exp_trig;
  } scn_t;

  int         n_chk;
  int         n_err;
  logic [7:0] hist[$];
  logic [7:0] got[$];
  bit         coll_en;
  int         rdy_mode;
  bit         run_done;
  bit         end_pend;
  bit         stall_prev;
  logic [7:0] held;
  int         valid_seen;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: drives tx_ready, records handshakes, checks stall stability and end of dump.
  initial begin
    tx_ready   = 1'b0;
    stall_prev = 1'b0;
    end_pend   = 1'b0;
    forever begin
      @(negedge clk);
      if (coll_en) begin
        case (rdy_mode)
          0:       tx_ready = 1'b1;
          1:       tx_ready = ($urandom_range(0, 1) == 1);
          default: tx_ready = 1'b0;
        endcase
        #1;
        if (stall_prev) begin
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", tx_data, held);
        end
        if (end_pend) begin
          chk("end_busy", busy, 0);
          chk("end_triggered", triggered, 0);
          chk("end_valid", tx_valid, 0);
          end_pend = 1'b0;
          run_done = 1'b1;
        end
        if (tx_valid) valid_seen++;
        if (tx_valid && tx_ready) begin
          got.push_back(tx_data);
          if (got.size() == EXP_N) begin
            chk("last_triggered", triggered, 1);
            end_pend = 1'b1;
          end
        end
        stall_prev = tx_valid && !tx_ready;
        held       = tx_data;
      end else begin
        tx_ready   = 1'b0;
        stall_prev = 1'b0;
        end_pend   = 1'b0;
      end
    end
  end

  // One ADC value per SAMPLE_DIV clocks; arm is pulsed together with the first value.
  task automatic drive(input scn_t sc, input int max_steps, input bit stop_on_valid);
    bit r1 = 1'b0;
    bit r2 = 1'b0;
    logic [7:0] v;
    for (int k = 0; k < max_steps; k++) begin
      if (run_done) break;
      if (stop_on_valid && tx_valid) break;
      case (sc.pat)
        0:       v = 8'(30 + k);
        1:       v = (k < 80) ? 8'd50 : 8'd150;
        2:       v = 8'($urandom_range(0, 255));
        default: v = (k < 100) ? 8'd200 : 8'd50;
      endcase
      adcIn = v;
      hist.push_back(v);
      if (k == 0) arm = 1'b1;
      else if (sc.rearm && triggered && !r1) begin arm = 1'b1; r1 = 1'b1; end
      else if (sc.rearm && got.size() > 8 && !r2) begin arm = 1'b1; r2 = 1'b1; end
      @(negedge clk);
      arm = 1'b0;
      repeat (SAMPLE_DIV - 1) @(negedge clk);
    end
  endtask

  // Reference: first crossing at or after sample PRE_TRIG; window is PRE_TRIG before to DEPTH total.
  function automatic int model_byte(input int t, input int j);
    int idx;
    if (j < HO) return (j == 0) ? 8'hA5 : (PRE_TRIG & 8'hFF);
    if (t < 0) return -1;
    idx = t - PRE_TRIG + (j - HO);
    if (idx < 0 || idx >= hist.size()) return -1;
    return int'(hist[idx]);
  endfunction

  task automatic run_scn(input scn_t sc, input string nm);
    int t;
    int bad;
    int e;
    int breaks;
    hist.delete();
    got.delete();
    run_done   = 1'b0;
    valid_seen = 0;
    trig_level = sc.level;
    rdy_mode   = sc.rdy;
    coll_en    = 1'b1;
    drive(sc, sc.exp_trig ? 700 : 150, 1'b0);
    if (sc.exp_trig) begin
      repeat (40) @(negedge clk);
      chk({nm, "_bytes"}, got.size(), EXP_N);
      t = -1;
      for (int i = (PRE_TRIG > 0 ? PRE_TRIG : 1); i < hist.size() && t < 0; i++)
        if (hist[i-1] < sc.level && hist[i] >= sc.level) t = i;
      bad = -1;
      e   = 0;
      for (int j = 0; j < got.size() && j < EXP_N && bad < 0; j++) begin
        e = model_byte(t, j);
        if (e < 0 || int'(got[j]) != e) bad = j;
      end
      n_chk++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL %s_stream: byte[%0d] got %0d expected %0d", nm, bad, got[bad], e);
      end
      if (sc.pat == 0 && got.size() >= EXP_N) begin
        chk({nm, "_byte64"}, got[HO+64], 100);
        chk({nm, "_byte63"}, got[HO+63], 99);
        breaks = 0;
        for (int j = HO + 1; j < EXP_N; j++)
          if (got[j] != 8'(got[j-1] + 8'd1)) breaks++;
        chk({nm, "_ramp_steps"}, breaks, 0);
`ifdef CAPTURE_HEADER_EN
        chk({nm, "_hdr_sync"}, got[0], 8'hA5);
        chk({nm, "_hdr_pre"}, got[1], 8'h40);
`endif
      end
    end else begin
      chk({nm, "_valid_seen"}, valid_seen, 0);
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_triggered"}, triggered, 0);
      chk({nm, "_bytes"}, got.size(), 0);
    end
    coll_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  scn_t tbl[5];
  scn_t s_rst;

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; arm = 1'b0; adcIn = '0; trig_level = '0;
    coll_en = 1'b0; rdy_mode = 0; run_done = 1'b0; valid_seen = 0;

    tbl[0] = '{pat: 0, level: 8'd100, rdy: 0, rearm: 1'b0, exp_trig: 1'b1};
    tbl[1] = '{pat: 1, level: 8'd100, rdy: 1, rearm: 1'b0, exp_trig: 1'b1};
    tbl[2] = '{pat: 1, level: 8'd100, rdy: 0, rearm: 1'b1, exp_trig: 1'b1};
    tbl[3] = '{pat: 2, level: 8'($urandom_range(1, 255)), rdy: 1, rearm: 1'b0, exp_trig: 1'b1};
    tbl[4] = '{pat: 3, level: 8'd100, rdy: 0, rearm: 1'b0, exp_trig: 1'b0};
    s_rst  = '{pat: 1, level: 8'd100, rdy: 2, rearm: 1'b0, exp_trig: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_triggered", triggered, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", tx_valid, 0);

    for (int i = 0; i < 5; i++) begin
      run_scn(tbl[i], $sformatf("scn%0d", i));
      if (!tbl[i].exp_trig) begin
        pulse_reset();
        chk($sformatf("scn%0d_after_reset_busy", i), busy, 0);
      end
    end

    // Reset while a byte is offered and stalled.
    hist.delete();
    got.delete();
    run_done   = 1'b0;
    valid_seen = 0;
    trig_level = s_rst.level;
    rdy_mode   = s_rst.rdy;
    coll_en    = 1'b1;
    drive(s_rst, 700, 1'b1);
    chk("rstdump_valid_before", tx_valid, 1);
    chk("rstdump_busy_before", busy, 1);
    coll_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstdump_valid", tx_valid, 0);
    chk("rstdump_busy", busy, 0);
    chk("rstdump_triggered", triggered, 0);
    chk("rstdump_data", tx_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_scn(tbl[0], "restart");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
